y_alu: RTL and testbench

- 32-bit integer ALU with a registered result.
- Performs AND, OR, ADD and SUB on two 32-bit operands, selected by a 3-bit opcode.
- Outputs the result and a zero flag.
- Sits in the datapath execute stage; its opcode encoding is the one the control unit drives.

---
 rtl/y_alu.sv | 54 +++++
 tb/tb_y_alu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/y_alu.sv
// Execute-stage integer ALU: AND/OR/ADD/SUB on two operands with a registered
// result and registered zero flag, one cycle of latency.
module y_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z,
    output logic             ex
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110
    } op_e;

    logic             sub;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result;

    // op[2] turns the shared adder into a subtractor: a + ~b + 1.
    assign sub   = op[2];
    assign b_sel = b ^ {WIDTH{sub}};
    assign sum   = a + b_sel + {{(WIDTH-1){1'b0}}, sub};

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = sum;
            OP_SUB:  result = sum;
            default: result = '0;
        endcase
    end

    // Output register stage; reset reads as a zero result, so the flag is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z  <= '0;
            ex <= 1'b1;
        end else begin
            z  <= result;
            ex <= ~|result;
        end
    end

endmodule

// File: tb/tb_y_alu.sv
// Directed and randomized checks for y_alu against hand-computed values and a
// small reference model with one-cycle latency.
module tb_y_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] z;
    logic        ex;

    int n_checks = 0;
    int n_errors = 0;

    y_alu #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .op (op),
        .z  (z),
        .ex (ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive operands away from the edge, then sample just after the capturing edge.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic [2:0] top, input logic [31:0] ez, input logic eex);
        @(negedge clk);
        a  = ta;
        b  = tb_;
        op = top;
        @(posedge clk);
        #1;
        check({tag, ".z"}, z, ez);
        check({tag, ".ex"}, {31'b0, ex}, {31'b0, eex});
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] ra, input logic [31:0] rb,
                                            input logic [2:0] rop);
        case (rop)
            3'b000:  return ra & rb;
            3'b001:  return ra | rb;
            3'b010:  return ra + rb;
            3'b110:  return ra - rb;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [2:0]  legal [4];
        logic [31:0] ra, rb, ez;
        legal[0] = 3'b000;
        legal[1] = 3'b001;
        legal[2] = 3'b010;
        legal[3] = 3'b110;

        rst = 1'b1;
        a   = 32'h1234_5678;
        b   = 32'h0000_0001;
        op  = 3'b010;
        #2;
        check("rst_z", z, 32'h0);
        check("rst_ex", {31'b0, ex}, 32'h1);
        @(posedge clk);
        #1;
        check("rst_hold_z", z, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("and", 32'hF0F0_1234, 32'h0FF0_FF00, 3'b000, 32'h00F0_1200, 1'b0);
        run_op("or",  32'hF0F0_1234, 32'h0FF0_FF00, 3'b001, 32'hFFF0_FF34, 1'b0);
        run_op("add", 32'd100, 32'd23, 3'b010, 32'd123, 1'b0);
        run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'b010, 32'h0, 1'b1);
        run_op("sub_eq", 32'd50, 32'd50, 3'b110, 32'h0, 1'b1);
        run_op("sub_neg", 32'd0, 32'd1, 3'b110, 32'hFFFF_FFFF, 1'b0);
        run_op("sub_pos", 32'd1000, 32'd1, 3'b110, 32'd999, 1'b0);
        run_op("add_big", 32'h8000_0000, 32'h8000_0001, 3'b010, 32'h0000_0001, 1'b0);
        run_op("nop011", 32'd5, 32'd7, 3'b011, 32'h0, 1'b1);
        run_op("nop100", 32'd5, 32'd7, 3'b100, 32'h0, 1'b1);
        run_op("nop101", 32'd5, 32'd7, 3'b101, 32'h0, 1'b1);
        run_op("nop111", 32'd5, 32'd7, 3'b111, 32'h0, 1'b1);
        run_op("and_zero", 32'hAAAA_AAAA, 32'h5555_5555, 3'b000, 32'h0, 1'b1);

        // Asynchronous reset mid-cycle after a nonzero result.
        run_op("pre_rst", 32'd7, 32'd8, 3'b010, 32'd15, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_z", z, 32'h0);
        check("async_rst_ex", {31'b0, ex}, 32'h1);
        @(posedge clk);
        #1;
        check("rst_held_z", z, 32'h0);
        check("rst_held_ex", {31'b0, ex}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_z", z, 32'd15);

        // Back-to-back random operations per legal opcode.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 12; i++) begin
                ra = $urandom;
                rb = (i == 0) ? ra : $urandom;
                ez = ref_alu(ra, rb, legal[k]);
                run_op("rand", ra, rb, legal[k], ez, (ez == 32'h0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
